// File: rtl/trig_pattern_mem.sv
// Trigger-pattern buffer.
// Holds a 2^AW x DW table of trigger words, which is loaded through a write port.
// Returns a framed stream of words for each read-enable burst from the trigger
// sequencer. Framing marks start-of-burst and the 2^AW-1 -> 0 address wrap.
// Each finished burst also produces a saturating burst-length summary.
// Pipeline: read register (edge k), S1 (edge k+1), output register S2 (edge k+2).
module trig_pattern_mem #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wena,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rena,
    input  logic [AW-1:0] raddr,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_sof,
    output logic          out_wrap,
    output logic [15:0]   burst_len,
    output logic          burst_done
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

    // Control word that travels alongside each read through the pipeline.
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic          sof;
        logic          wrap;
        logic          done;
        logic [15:0]   len;
    } ctl_t;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] r_s1_data;
    ctl_t          r_rd_ctl;
    ctl_t          r_s1_ctl;
    logic          r_prev_rena;
    logic [AW-1:0] r_prev_raddr;
    logic [15:0]   r_cnt;

    logic          w_cont;
    logic          w_sof;
    logic          w_wrap;
    logic          w_end;

    // Burst framing decoded from this cycle's request and the previous one.
    assign w_cont = rena & r_prev_rena;
    assign w_sof  = rena & ~r_prev_rena;
    assign w_wrap = w_cont & (raddr == '0) & (r_prev_raddr == ADDR_MAX);
    assign w_end  = ~rena & r_prev_rena;

    // Table write and registered read.
    // The read samples the old contents when it collides with a write.
    // NOTE: the table has no reset branch, so it can map onto block RAM; rst
    // leaves the stored patterns intact.
    always_ff @(posedge clk) begin
        if (wena) begin
            r_mem[waddr] <= wdata;
        end
        r_rd_data <= r_mem[raddr];
    end

    // Request sampling: framing flags, previous-cycle history and burst counter.
    // NOTE: every sequential assignment is non-blocking, so all of these
    // registers see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ctl     <= '0;
            r_prev_rena  <= 1'b0;
            r_prev_raddr <= '0;
            r_cnt        <= '0;
        end else begin
            r_rd_ctl.valid <= rena;
            r_rd_ctl.addr  <= raddr;
            r_rd_ctl.sof   <= w_sof;
            r_rd_ctl.wrap  <= w_wrap;
            r_rd_ctl.done  <= w_end;
            r_rd_ctl.len   <= r_cnt;
            r_prev_rena    <= rena;
            r_prev_raddr   <= raddr;
            if (w_sof) begin
                r_cnt <= 16'd1;
            end else if (w_cont && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // S1: align control with the read data.
    // The data register only loads for valid words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_ctl  <= '0;
            r_s1_data <= '0;
        end else begin
            r_s1_ctl <= r_rd_ctl;
            if (r_rd_ctl.valid) begin
                r_s1_data <= r_rd_data;
            end
        end
    end

    // S2: registered outputs.
    // burst_len holds its value between burst ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_sof    <= 1'b0;
            out_wrap   <= 1'b0;
            burst_done <= 1'b0;
            burst_len  <= '0;
        end else begin
            out_valid  <= r_s1_ctl.valid;
            out_addr   <= r_s1_ctl.addr;
            out_sof    <= r_s1_ctl.sof;
            out_wrap   <= r_s1_ctl.wrap;
            burst_done <= r_s1_ctl.done;
            if (r_s1_ctl.valid) begin
                out_data <= r_s1_data;
            end
            if (r_s1_ctl.done) begin
                burst_len <= r_s1_ctl.len;
            end
        end
    end

endmodule

// File: tb/tb_trig_pattern_mem.sv
// Self-checking bench for trig_pattern_mem.
// A behavioural model pushes expected words and burst summaries into queues as
// stimulus is applied, and they are popped when due. A vector table covers the
// basic load/readback. Hand-written sequences cover wrap, collision,
// back-to-back bursts, saturation and reset mid-burst.
module tb_trig_pattern_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wena = 1'b0;
    logic [11:0] waddr = '0;
    logic [15:0] wdata = '0;
    logic        rena = 1'b0;
    logic [11:0] raddr = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [11:0] out_addr;
    logic        out_sof;
    logic        out_wrap;
    logic [15:0] burst_len;
    logic        burst_done;

    trig_pattern_mem #(.AW(12), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wena       (wena),
        .waddr      (waddr),
        .wdata      (wdata),
        .rena       (rena),
        .raddr      (raddr),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_sof    (out_sof),
        .out_wrap   (out_wrap),
        .burst_len  (burst_len),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [15:0] data;
        logic        sof;
        logic        wrap;
    } exp_word_t;

    typedef struct {
        int          due;
        logic [15:0] len;
    } exp_done_t;

    typedef struct {
        logic        rena;
        logic [11:0] raddr;
        logic        exp_valid;
        logic [11:0] exp_addr;
        logic [15:0] exp_data;
        logic        exp_sof;
        logic        exp_done;
        logic [15:0] exp_len;
    } vec_t;

    exp_word_t   q_word[$];
    exp_done_t   q_done[$];
    logic [15:0] q_lens[$];
    vec_t        tbl[20];

    logic [15:0] m_mem [4096];
    logic        m_prev;
    logic [11:0] m_prev_addr;
    logic [15:0] m_cnt;
    logic [15:0] m_len;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          n_sof;
    int          n_wrap;
    logic [11:0] wrap_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_sof  = 0;
        n_wrap = 0;
        wrap_addr = '0;
        q_lens.delete();
    endtask

    // Advance one clock: update the model with the inputs about to be sampled,
    // then compare outputs #1 after the edge.
    task automatic tick();
        exp_word_t w;
        exp_done_t d;
        logic      sof;
        logic      wrap;
        logic      endf;
        if (rst) begin
            q_word.delete();
            q_done.delete();
            m_prev      = 1'b0;
            m_prev_addr = '0;
            m_cnt       = '0;
            m_len       = '0;
        end else begin
            sof  = rena && !m_prev;
            wrap = rena && m_prev && (raddr == 12'd0) && (m_prev_addr == 12'hFFF);
            endf = !rena && m_prev;
            if (rena) begin
                w.due  = cyc + 3;
                w.addr = raddr;
                w.data = m_mem[raddr];
                w.sof  = sof;
                w.wrap = wrap;
                q_word.push_back(w);
            end
            if (endf) begin
                d.due = cyc + 3;
                d.len = m_cnt;
                q_done.push_back(d);
            end
            if (sof) m_cnt = 16'd1;
            else if (rena && m_prev && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_prev      = rena;
            m_prev_addr = raddr;
        end
        if (wena) m_mem[waddr] = wdata;

        @(posedge clk);
        cyc++;
        #1;

        if (q_word.size() > 0 && q_word[0].due == cyc) begin
            w = q_word.pop_front();
            check("sb_valid", out_valid, 1'b1);
            check("sb_addr",  out_addr,  w.addr);
            check("sb_data",  out_data,  w.data);
            check("sb_sof",   out_sof,   w.sof);
            check("sb_wrap",  out_wrap,  w.wrap);
        end else begin
            check("sb_idle_valid", out_valid, 1'b0);
            check("sb_idle_sof",   out_sof,   1'b0);
            check("sb_idle_wrap",  out_wrap,  1'b0);
        end
        if (q_done.size() > 0 && q_done[0].due == cyc) begin
            d = q_done.pop_front();
            m_len = d.len;
            check("sb_done", burst_done, 1'b1);
        end else begin
            check("sb_no_done", burst_done, 1'b0);
        end
        check("sb_len", burst_len, m_len);

        if (out_valid === 1'b1 && out_sof === 1'b1) n_sof++;
        if (out_valid === 1'b1 && out_wrap === 1'b1) begin
            n_wrap++;
            wrap_addr = out_addr;
        end
        if (burst_done === 1'b1) q_lens.push_back(burst_len);
    endtask

    task automatic idle(input int n);
        rena = 1'b0;
        wena = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        clear_stats();

        // Load/readback vectors: outputs expected two edges after each request.
        for (int j = 0; j < 20; j++) begin
            tbl[j].rena      = (j < 16);
            tbl[j].raddr     = (j < 16) ? 12'(j) : 12'd0;
            tbl[j].exp_valid = (j >= 2) && (j < 18);
            tbl[j].exp_addr  = 12'(j - 2);
            tbl[j].exp_data  = 16'(j - 2) ^ 16'hA5A5;
            tbl[j].exp_sof   = (j == 2);
            tbl[j].exp_done  = (j == 18);
            tbl[j].exp_len   = (j >= 18) ? 16'd16 : 16'd0;
        end

        // Reset state.
        tick();
        tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_sof",   out_sof,   1'b0);
        check("rst_done",  burst_done, 1'b0);
        check("rst_len",   burst_len, 16'd0);
        check("rst_data",  out_data,  16'd0);
        rst = 1'b0;

        // Load the first 16 entries.
        for (int i = 0; i < 16; i++) begin
            wena  = 1'b1;
            waddr = 12'(i);
            wdata = 16'(i) ^ 16'hA5A5;
            tick();
        end
        wena = 1'b0;

        // Table-driven readback of addresses 0..15.
        clear_stats();
        for (int j = 0; j < 20; j++) begin
            rena  = tbl[j].rena;
            raddr = tbl[j].raddr;
            tick();
            check("tbl_valid", out_valid, tbl[j].exp_valid);
            if (tbl[j].exp_valid) begin
                check("tbl_addr", out_addr, tbl[j].exp_addr);
                check("tbl_data", out_data, tbl[j].exp_data);
            end
            check("tbl_sof",  out_sof,    tbl[j].exp_sof);
            check("tbl_done", burst_done, tbl[j].exp_done);
            check("tbl_len",  burst_len,  tbl[j].exp_len);
        end
        idle(2);

        // Wrap: 4094, 4095, 0, 1.
        wena = 1'b1;
        waddr = 12'd4094; wdata = 16'hBEE0; tick();
        waddr = 12'd4095; wdata = 16'hBEE1; tick();
        waddr = 12'd0;    wdata = 16'hBEE2; tick();
        waddr = 12'd1;    wdata = 16'hBEE3; tick();
        wena = 1'b0;
        clear_stats();
        rena = 1'b1;
        raddr = 12'd4094; tick();
        raddr = 12'd4095; tick();
        raddr = 12'd0;    tick();
        raddr = 12'd1;    tick();
        idle(4);
        check("wrap_count", n_wrap, 1);
        check("wrap_addr",  wrap_addr, 12'd0);
        check("wrap_len",   burst_len, 16'd4);

        // Read/write collision on address 5.
        wena = 1'b1; waddr = 12'd5; wdata = 16'h1111; rena = 1'b0;
        tick();
        wdata = 16'h2222; rena = 1'b1; raddr = 12'd5;
        tick();
        wena = 1'b0;
        tick();
        rena = 1'b0;
        tick();
        check("coll_old_valid", out_valid, 1'b1);
        check("coll_old_data",  out_data,  16'h1111);
        tick();
        check("coll_new_valid", out_valid, 1'b1);
        check("coll_new_data",  out_data,  16'h2222);
        idle(3);

        // Back-to-back bursts: 3 high, 1 low, 2 high.
        clear_stats();
        rena = 1'b1;
        for (int i = 0; i < 3; i++) begin raddr = 12'(i); tick(); end
        rena = 1'b0; tick();
        rena = 1'b1;
        for (int i = 3; i < 5; i++) begin raddr = 12'(i); tick(); end
        idle(4);
        check("b2b_sof_count",  n_sof, 2);
        check("b2b_done_count", q_lens.size(), 2);
        if (q_lens.size() == 2) begin
            check("b2b_len0", q_lens[0], 16'd3);
            check("b2b_len1", q_lens[1], 16'd2);
        end

        // Saturation: 70000-word burst cycling through addresses 0..15.
        clear_stats();
        rena = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            raddr = 12'(i % 16);
            tick();
        end
        idle(4);
        check("sat_len",        burst_len, 16'hFFFF);
        check("sat_done_count", q_lens.size(), 1);
        check("sat_no_wrap",    n_wrap, 0);

        // Reset mid-burst with rena held high.
        clear_stats();
        rena = 1'b1;
        for (int i = 0; i < 3; i++) begin raddr = 12'(i); tick(); end
        rst = 1'b1; raddr = 12'd3;
        tick();
        check("mrst_valid", out_valid,  1'b0);
        check("mrst_data",  out_data,   16'd0);
        check("mrst_addr",  out_addr,   12'd0);
        check("mrst_sof",   out_sof,    1'b0);
        check("mrst_wrap",  out_wrap,   1'b0);
        check("mrst_done",  burst_done, 1'b0);
        check("mrst_len",   burst_len,  16'd0);
        rst = 1'b0;
        raddr = 12'd4; tick();
        check("mrst_gap1_valid", out_valid, 1'b0);
        raddr = 12'd5; tick();
        check("mrst_gap2_valid", out_valid, 1'b0);
        raddr = 12'd6; tick();
        check("mrst_new_sof",  out_sof,  1'b1);
        check("mrst_new_addr", out_addr, 12'd4);
        raddr = 12'd7; tick();
        idle(4);
        check("mrst_done_count", q_lens.size(), 1);
        check("mrst_len_after",  burst_len, 16'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
